dfd_dst_priority_demux: RTL and testbench

Routes a single valid/ready stream of WIDTH-bit words to one of LEVELS destinations. The destination is the highest-indexed bit set in a per-word select vector, the same priority rule the destination priority mux uses on the collecting side. Each destination has a one-entry registered output slot with its own valid/ready handshake, so a stalled destination only blocks words aimed at it. Words arriving with an empty select vector are consumed, discarded and counted.

---
 rtl/dfd_dst_pkg.sv | 32 +++
 rtl/dfd_dst_slot.sv | 31 +++
 rtl/dfd_dst_priority_demux.sv | 76 +++++++
 tb/tb_dfd_dst_priority_demux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dfd_dst_pkg.sv
// Shared definitions for the destination priority demux and priority mux:
// default sizes and the highest-set-bit priority decoder.
package dfd_dst_pkg;

   localparam int DFD_DST_WIDTH      = 8;
   localparam int DFD_DST_LEVELS     = 4;
   // Widest select vector the decoder accepts; LEVELS must not exceed this.
   localparam int DFD_DST_MAX_LEVELS = 32;
   localparam int DFD_DST_IDX_W      = 5;

   typedef struct packed {
      logic                     found;
      logic [DFD_DST_IDX_W-1:0] idx;
   } dfd_dst_prio_t;

   // Index of the highest set bit; found is 0 for an all-zero vector.
   function automatic dfd_dst_prio_t dfd_dst_prio_idx(
      input logic [DFD_DST_MAX_LEVELS-1:0] select
   );
      dfd_dst_prio_t r;
      r = '0;
      // Ascending scan: the last set bit seen is the highest one.
      for (int i = 0; i < DFD_DST_MAX_LEVELS; i++) begin
         if (select[i]) begin
            r.found = 1'b1;
            r.idx   = DFD_DST_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dfd_dst_slot.sv
// One-entry registered output slot with load/drain handshake.
// A load and a drain in the same cycle keep the slot full with the new word.
module dfd_dst_slot
   import dfd_dst_pkg::*;
#(
   parameter int WIDTH = DFD_DST_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Slot state: load wins over drain; data only moves on a load, so it is
   // held stable while the consumer stalls and ignores the data input otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dfd_dst_priority_demux.sv
// Routes one valid/ready stream to the destination named by the highest set
// bit of in_select. Each destination has its own one-entry slot so a stalled
// consumer only blocks words aimed at it. Empty selects are dropped and counted.
module dfd_dst_priority_demux
   import dfd_dst_pkg::*;
#(
   parameter int WIDTH  = DFD_DST_WIDTH,
   parameter int LEVELS = DFD_DST_LEVELS,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [LEVELS-1:0] in_select,
   output logic [LEVELS-1:0] out_valid,
   input  logic [LEVELS-1:0] out_ready,
   output logic [WIDTH-1:0]  out_data [0:LEVELS-1],
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              busy
);

   logic [DFD_DST_MAX_LEVELS-1:0] sel_ext;
   dfd_dst_prio_t                 prio;
   logic [LEVELS-1:0]             hot;
   logic [LEVELS-1:0]             can_take;
   logic [LEVELS-1:0]             load;
   logic                          accept;
   logic                          drop;

   // Target decode: one-hot of the highest set select bit (all zero when none).
   always_comb begin
      sel_ext              = '0;
      sel_ext[LEVELS-1:0]  = in_select;
      prio                 = dfd_dst_prio_idx(sel_ext);
      hot                  = '0;
      for (int i = 0; i < LEVELS; i++) begin
         hot[i] = prio.found && (prio.idx == DFD_DST_IDX_W'(i));
      end
   end

   // A slot can take a word when empty or draining this cycle.
   assign can_take = ~out_valid | out_ready;

   // Ready follows only the targeted slot; drops are always accepted.
   assign in_ready = prio.found ? |(hot & can_take) : 1'b1;
   assign accept   = in_valid & in_ready;
   assign load     = hot & {LEVELS{accept}};
   assign drop     = accept & ~prio.found;
   assign busy     = |out_valid;

   // Drop counter: saturates at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < LEVELS; g++) begin : g_slot
      dfd_dst_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk      (clk),
         .reset    (reset),
         .load     (load[g]),
         .load_data(in_data),
         .ready    (out_ready[g]),
         .valid    (out_valid[g]),
         .data     (out_data[g])
      );
   end

endmodule

// File: tb/tb_dfd_dst_priority_demux.sv
// Bench for dfd_dst_priority_demux: table of directed single-cycle vectors,
// hand sequences for reset and saturation, then randomized traffic against a
// per-destination queue model.
module tb_dfd_dst_priority_demux;

   localparam int W = 8;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [L-1:0] in_select;
   logic [L-1:0] out_valid;
   logic [L-1:0] out_ready;
   logic [W-1:0] out_data [0:L-1];
   logic [15:0]  drop_cnt;
   logic         busy;

   logic         in_ready4;
   logic [L-1:0] out_valid4;
   logic [W-1:0] out_data4 [0:L-1];
   logic [3:0]   drop_cnt4;
   logic         busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dfd_dst_priority_demux #(.WIDTH(W), .LEVELS(L), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_select(in_select), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt), .busy(busy)
   );

   dfd_dst_priority_demux #(.WIDTH(W), .LEVELS(L), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_select(in_select), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .drop_cnt(drop_cnt4), .busy(busy4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Highest set index of a select vector, -1 when empty.
   function automatic int target_of(input logic [L-1:0] s);
      for (int i = L - 1; i >= 0; i--) if (s[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic         v;
      logic [L-1:0] sel;
      logic [W-1:0] d;
      logic [L-1:0] rdy;
      logic         exp_rdy;
      logic [L-1:0] exp_ov;
      int           slot;
      logic [W-1:0] exp_d;
      int           exp_drop;
   } vec_t;

   vec_t tbl [13];

   // Reference model: words accepted but not yet consumed, per destination.
   logic [W-1:0] pend [L][$];
   int           model_drop;

   task automatic rand_cycle(input bit stream);
      int t;
      bit exp_rdy;
      in_valid  = stream ? 1'b1 : (($urandom % 4) != 0);
      in_select = stream ? L'($urandom_range(1, (1 << L) - 1))
                         : ((($urandom % 5) == 0) ? '0 : L'($urandom));
      in_data   = W'($urandom);
      out_ready = stream ? '1 : L'($urandom);
      #1;
      t = target_of(in_select);
      exp_rdy = (t < 0) || (pend[t].size() == 0) || out_ready[t];
      chk("rnd_in_ready", in_ready, exp_rdy);
      for (int i = 0; i < L; i++) begin
         chk("rnd_out_valid", out_valid[i], pend[i].size() != 0);
         if (out_valid[i] && out_ready[i] && pend[i].size() != 0) begin
            chk("rnd_out_data", out_data[i], pend[i][0]);
            void'(pend[i].pop_front());
         end
      end
      if (in_valid && exp_rdy) begin
         if (t < 0) model_drop++;
         else pend[t].push_back(in_data);
      end
      @(posedge clk); #1;
      chk("rnd_drop_cnt", drop_cnt, sat(model_drop, 65535));
      chk("rnd_drop_cnt4", drop_cnt4, sat(model_drop, 15));
   endtask

   initial begin
      // Directed vectors, applied one per cycle from an empty, reset design.
      tbl[0]  = '{1'b1, 4'b0110, 8'hA5, 4'hF, 1'b1, 4'b0100, 2, 8'hA5, 0};
      tbl[1]  = '{1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 4'b0000, 1, 8'h00, 0};
      tbl[2]  = '{1'b1, 4'b1000, 8'h11, 4'h0, 1'b1, 4'b1000, 3, 8'h11, 0};
      tbl[3]  = '{1'b1, 4'b1000, 8'h22, 4'h0, 1'b0, 4'b1000, 3, 8'h11, 0};
      tbl[4]  = '{1'b1, 4'b0001, 8'h33, 4'h0, 1'b1, 4'b1001, 0, 8'h33, 0};
      tbl[5]  = '{1'b1, 4'b1000, 8'h22, 4'h8, 1'b1, 4'b1001, 3, 8'h22, 0};
      tbl[6]  = '{1'b1, 4'b0000, 8'h44, 4'h0, 1'b1, 4'b1001, 0, 8'h33, 1};
      tbl[7]  = '{1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 4'b0000, 3, 8'h22, 1};
      for (int k = 8; k < 13; k++)
         tbl[k] = '{1'b1, 4'b0000, 8'h55, 4'hF, 1'b1, 4'b0000, 3, 8'h22, k - 6};

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_select = '0; out_ready = '0;
      #1;
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      for (int k = 0; k < 13; k++) begin
         in_valid = tbl[k].v; in_select = tbl[k].sel;
         in_data = tbl[k].d; out_ready = tbl[k].rdy;
         #1;
         chk("tbl_in_ready", in_ready, tbl[k].exp_rdy);
         @(posedge clk); #1;
         chk("tbl_out_valid", out_valid, tbl[k].exp_ov);
         chk("tbl_busy", busy, |tbl[k].exp_ov);
         chk("tbl_out_data", out_data[tbl[k].slot], tbl[k].exp_d);
         chk("tbl_drop_cnt", drop_cnt, tbl[k].exp_drop);
         chk("tbl_drop_cnt4", drop_cnt4, sat(tbl[k].exp_drop, 15));
      end
      chk("slot1_untouched", out_data[1], 8'h00);

      // 20 more drops: wide counter keeps counting, 4-bit one saturates.
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1; in_select = '0; in_data = W'($urandom); out_ready = '1;
         #1;
         chk("drop_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
      end
      chk("drop_cnt_26", drop_cnt, 26);
      chk("drop_cnt4_sat", drop_cnt4, 4'hF);
      chk("drop_no_valid", out_valid, 4'b0000);

      // Fill slots 0 and 2 with stalled consumers, then reset between edges.
      in_valid = 1'b1; in_select = 4'b0001; in_data = 8'h66; out_ready = '0;
      @(posedge clk); #1;
      in_select = 4'b0100; in_data = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 4'b0101);
      chk("pre_rst_data2", out_data[2], 8'h77);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 4'b0000);
      chk("async_rst_data0", out_data[0], 8'h00);
      chk("async_rst_data2", out_data[2], 8'h00);
      chk("async_rst_drop", drop_cnt, 0);
      chk("async_rst_busy", busy, 1'b0);
      in_valid = 1'b1; in_select = 4'b0001; in_data = 8'h99;
      @(posedge clk); #1;
      chk("rst_accept_ignored", out_valid, 4'b0000);
      #2;
      reset = 1'b0;
      in_select = 4'b0010; in_data = 8'h88; out_ready = '1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_valid", out_valid, 4'b0010);
      chk("post_rst_data", out_data[1], 8'h88);
      @(posedge clk); #1;
      chk("post_rst_drained", out_valid, 4'b0000);

      // Randomized traffic against the queue model.
      model_drop = 0;
      for (int k = 0; k < 100; k++) rand_cycle(1'b1);
      for (int k = 0; k < 400; k++) rand_cycle(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
